systolic_2x2_feeder: RTL and testbench
======================================

SYSTOLIC_2X2_FEEDER -- requirements
Module: systolic_2x2_feeder

Interface
REQ-001 SHALL have parameter data_width, default 8, meaning operand element width in bits.
REQ-002 SHALL have parameter MM_CYCLES, default 15, meaning length of the array COMPUTE window in cycles; legal range 3..16.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, an operand pair is offered on in_a/in_b.
REQ-006 SHALL have port in_ready, output, 1, the feeder can accept an operand pair.
REQ-007 SHALL have port in_a, input, 4*data_width, matrix A packed as [dw-1:0]=A00, [2dw-1:dw]=A01, [3dw-1:2dw]=A10, [4dw-1:3dw]=A11.
REQ-008 SHALL have port in_b, input, 4*data_width, matrix B with the same packing (B00, B01, B10, B11).
REQ-009 SHALL have port start, output, 1, one-cycle start pulse to the systolic array.
REQ-010 SHALL have ports a0_out and a1_out, output, data_width each, skewed A row streams to the array a0_in and a1_in.
REQ-011 SHALL have ports b0_out and b1_out, output, data_width each, skewed B column streams to the array b0_in and b1_in.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-013 SHALL have port done, output, 1, one-cycle pulse in the cycle the array is in DONE.

Function
REQ-014 SHALL implement states IDLE, START, LOAD, FEED and DRAIN with a 4-bit feed counter k.
REQ-015 SHALL drive in_ready=1 only in IDLE; a transfer occurs on a clock edge where in_valid and in_ready are both 1.
REQ-016 SHALL capture in_a/in_b into internal registers on a transfer; in_a/in_b SHALL be ignored at all other times.
REQ-017 SHALL use these transitions: IDLE->START on transfer; START->LOAD; LOAD->FEED with k=0; FEED->FEED with k+1 while k<MM_CYCLES-1; FEED->DRAIN at k=MM_CYCLES-1; DRAIN->IDLE.
REQ-018 SHALL drive start=1 only in START, so that the array's S_LOAD coincides with the feeder's LOAD and the array's COMPUTE coincides with FEED.
REQ-019 In FEED at count k, SHALL drive a0_out=A0k for k in {0,1}, otherwise 0.
REQ-020 In FEED at count k, SHALL drive a1_out=A1(k-1) for k in {1,2}, otherwise 0.
REQ-021 In FEED at count k, SHALL drive b0_out=Bk0 for k in {0,1}, otherwise 0.
REQ-022 In FEED at count k, SHALL drive b1_out=B(k-1)1 for k in {1,2}, otherwise 0.
REQ-023 SHALL drive all four stream outputs to 0 in every state other than FEED.
REQ-024 SHALL register all outputs, with no combinational path from any input to any output.
REQ-025 SHALL give a fixed latency: transfer at edge T gives start high in cycle T+1, FEED in cycles T+3..T+2+MM_CYCLES, done in cycle T+3+MM_CYCLES, and in_ready high again in cycle T+4+MM_CYCLES.
REQ-026 SHALL support back-to-back operation: in_valid held high is accepted in the first IDLE cycle after DRAIN, with no extra bubble.
REQ-027 SHALL pass operands through unmodified; no arithmetic is done on data and widths are preserved.

Reset
REQ-028 On rst=1 at a clock edge, SHALL enter IDLE with k=0.
REQ-029 On reset, SHALL set start=0, busy=0, done=0 and all four stream outputs to 0.
REQ-030 On reset, SHALL set in_ready=1 in the first cycle after rst deasserts.
REQ-031 SHALL apply reset in any state, including mid-FEED, and SHALL discard the in-flight operands with no done pulse.
REQ-032 SHALL give rst priority over a transfer on the same edge.

Verification
REQ-033 Single op: A=[[1,2],[3,4]], B=[[5,6],[7,8]] gives FEED k0 (a0,a1,b0,b1)=(1,0,5,0), k1=(2,3,7,6), k2=(0,4,0,8), and zeros for k3..k14; done exactly 18 cycles after the transfer.
REQ-034 Integration with systolic_2x2 (same clk/rst): the single-op stimulus gives c00=19, c01=22, c10=43, c11=50 after done, and active_buffer toggles once.
REQ-035 Back-to-back: in_valid held with two different pairs gives second transfer in the cycle after done, and both result sets are correct.
REQ-036 Busy-time offer: in_valid pulsed during FEED with A=all 0xFF gives no capture, in_ready=0, and the stream values from the original operands.
REQ-037 Reset mid-FEED at k=5 gives all outputs 0 next cycle, no done pulse, in_ready=1 after rst deasserts, and a following op completes correctly.
REQ-038 Extremes: A=B=all 0xFF gives streams carrying 0xFF at the REQ-019..022 positions, and the array yields c00..c11=0xFC02.

Source files
------------

// File: rtl/systolic_2x2_feeder.sv
`default_nettype none
// ============================================================================
// Module      : systolic_2x2_feeder
// Description : Captures a 2x2 operand pair and streams it, row/column skewed,
//               into a 2x2 systolic array across a fixed COMPUTE window.
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_2x2_feeder #(
  parameter int data_width = 8,
  parameter int MM_CYCLES  = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*data_width-1:0] in_a,
  input  logic [4*data_width-1:0] in_b,
  output logic                    start,
  output logic [data_width-1:0]   a0_out,
  output logic [data_width-1:0]   a1_out,
  output logic [data_width-1:0]   b0_out,
  output logic [data_width-1:0]   b1_out,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_LOAD  = 3'd2,
    S_FEED  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  localparam logic [3:0] c_K_LAST = 4'(MM_CYCLES - 1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_k;
  logic [3:0]              w_k_nxt;
  logic [4*data_width-1:0] r_a;
  logic [4*data_width-1:0] r_b;
  logic                    w_xfer;

  logic                    r_in_ready;
  logic                    r_start;
  logic                    r_busy;
  logic                    r_done;
  logic [data_width-1:0]   r_a0;
  logic [data_width-1:0]   r_a1;
  logic [data_width-1:0]   r_b0;
  logic [data_width-1:0]   r_b1;
  logic [data_width-1:0]   w_a0_nxt;
  logic [data_width-1:0]   w_a1_nxt;
  logic [data_width-1:0]   w_b0_nxt;
  logic [data_width-1:0]   w_b1_nxt;

  assign w_xfer = in_valid && (r_state == S_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    case (r_state)
      S_IDLE: begin
        if (in_valid) w_state_nxt = S_START;
      end
      S_START: w_state_nxt = S_LOAD;
      S_LOAD: begin
        w_state_nxt = S_FEED;
        w_k_nxt     = 4'd0;
      end
      S_FEED: begin
        if (r_k == c_K_LAST) begin
          w_state_nxt = S_DRAIN;
          w_k_nxt     = 4'd0;
        end else begin
          w_k_nxt = r_k + 4'd1;
        end
      end
      S_DRAIN: w_state_nxt = S_IDLE;
      default: begin
        w_state_nxt = S_IDLE;
        w_k_nxt     = 4'd0;
      end
    endcase
  end

  // Stream values are decoded from the upcoming state/count so they appear registered.
  always_comb begin
    w_a0_nxt = '0;
    w_a1_nxt = '0;
    w_b0_nxt = '0;
    w_b1_nxt = '0;
    if (w_state_nxt == S_FEED) begin
      case (w_k_nxt)
        4'd0: begin
          w_a0_nxt = r_a[0*data_width +: data_width];
          w_b0_nxt = r_b[0*data_width +: data_width];
        end
        4'd1: begin
          w_a0_nxt = r_a[1*data_width +: data_width];
          w_a1_nxt = r_a[2*data_width +: data_width];
          w_b0_nxt = r_b[2*data_width +: data_width];
          w_b1_nxt = r_b[1*data_width +: data_width];
        end
        4'd2: begin
          w_a1_nxt = r_a[3*data_width +: data_width];
          w_b1_nxt = r_b[3*data_width +: data_width];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_k        <= 4'd0;
      r_in_ready <= 1'b1;
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_a0       <= '0;
      r_a1       <= '0;
      r_b0       <= '0;
      r_b1       <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_k        <= w_k_nxt;
      r_in_ready <= (w_state_nxt == S_IDLE);
      r_start    <= (w_state_nxt == S_START);
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= (w_state_nxt == S_DRAIN);
      r_a0       <= w_a0_nxt;
      r_a1       <= w_a1_nxt;
      r_b0       <= w_b0_nxt;
      r_b1       <= w_b1_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
    end else if (w_xfer) begin
      r_a <= in_a;
      r_b <= in_b;
    end
  end

  assign in_ready = r_in_ready;
  assign start    = r_start;
  assign busy     = r_busy;
  assign done     = r_done;
  assign a0_out   = r_a0;
  assign a1_out   = r_a1;
  assign b0_out   = r_b0;
  assign b1_out   = r_b1;

endmodule
`default_nettype wire

// File: tb/tb_systolic_2x2_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_2x2_feeder
// Description : Directed self-checking bench for systolic_2x2_feeder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_2x2_feeder;

  localparam int DW = 8;
  localparam int MM = 15;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [4*DW-1:0] in_a;
  logic [4*DW-1:0] in_b;
  logic          start;
  logic [DW-1:0] a0_out;
  logic [DW-1:0] a1_out;
  logic [DW-1:0] b0_out;
  logic [DW-1:0] b1_out;
  logic          busy;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] cap [0:15];

  systolic_2x2_feeder #(.data_width(DW), .MM_CYCLES(MM)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .start(start),
    .a0_out(a0_out), .a1_out(a1_out), .b0_out(b0_out), .b1_out(b1_out),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected {a0,a1,b0,b1} at feed count k, straight from the skew table.
  function automatic logic [31:0] exp_stream(input logic [31:0] a, input logic [31:0] b, input int k);
    logic [7:0] ea0, ea1, eb0, eb1;
    ea0 = 8'd0; ea1 = 8'd0; eb0 = 8'd0; eb1 = 8'd0;
    case (k)
      0: begin ea0 = a[7:0];   eb0 = b[7:0]; end
      1: begin ea0 = a[15:8];  ea1 = a[23:16]; eb0 = b[23:16]; eb1 = b[15:8]; end
      2: begin ea1 = a[31:24]; eb1 = b[31:24]; end
      default: ;
    endcase
    return {ea0, ea1, eb0, eb1};
  endfunction

  // 2x2 product (16-bit accumulators) rebuilt from the captured streams.
  function automatic logic [63:0] cap_product();
    logic [15:0] ma00, ma01, ma10, ma11, mb00, mb01, mb10, mb11;
    logic [15:0] c00, c01, c10, c11;
    ma00 = {8'd0, cap[0][31:24]}; ma01 = {8'd0, cap[1][31:24]};
    ma10 = {8'd0, cap[1][23:16]}; ma11 = {8'd0, cap[2][23:16]};
    mb00 = {8'd0, cap[0][15:8]};  mb10 = {8'd0, cap[1][15:8]};
    mb01 = {8'd0, cap[1][7:0]};   mb11 = {8'd0, cap[2][7:0]};
    c00 = ma00 * mb00 + ma01 * mb10;
    c01 = ma00 * mb01 + ma01 * mb11;
    c10 = ma10 * mb00 + ma11 * mb10;
    c11 = ma10 * mb01 + ma11 * mb11;
    return {c00, c01, c10, c11};
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Entered at the sampling point of the cycle right after the transfer edge.
  task automatic watch_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_c, input int poke_cycle);
    int done_at   = -1;
    int done_cnt  = 0;
    int ready_bad = 0;
    for (int c = 1; c <= MM + 4; c++) begin
      if (c > 1) @(negedge clk);
      if (poke_cycle > 0 && c == poke_cycle) begin
        in_valid = 1'b1; in_a = '1; in_b = '1;
      end
      if (poke_cycle > 0 && c == poke_cycle + 1) in_valid = 1'b0;
      if (done) begin done_cnt++; done_at = c; end
      if (c <= MM + 3 && in_ready) ready_bad++;
      if (c == 1) check({tag, " start"}, {62'd0, start, busy}, 64'd3);
      if (c == 2) check({tag, " load"}, {start, a0_out, a1_out, b0_out, b1_out}, 64'd0);
      if (c >= 3 && c <= MM + 2) begin
        cap[c-3] = {a0_out, a1_out, b0_out, b1_out};
        check($sformatf("%s k%0d", tag, c - 3), {32'd0, cap[c-3]}, {32'd0, exp_stream(a, b, c - 3)});
      end
      if (c == MM + 3) check({tag, " drain"}, {done, a0_out, a1_out, b0_out, b1_out}, 64'h1_0000_0000);
      if (c == MM + 4) check({tag, " idle"}, {61'd0, in_ready, busy, done}, 64'd4);
    end
    check({tag, " done_at"}, 64'(done_at), 64'd18);
    check({tag, " done_cnt"}, 64'(done_cnt), 64'd1);
    check({tag, " ready_low"}, 64'(ready_bad), 64'd0);
    check({tag, " product"}, cap_product(), exp_c);
  endtask

  localparam logic [31:0] OP1_A = {8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [31:0] OP1_B = {8'd8, 8'd7, 8'd6, 8'd5};
  localparam logic [31:0] OP2_A = {8'd3, 8'd1, 8'd0, 8'd2};
  localparam logic [31:0] OP2_B = {8'd2, 8'd0, 8'd1, 8'd4};
  localparam logic [31:0] OP3_A = {8'd8, 8'd7, 8'd6, 8'd5};
  localparam logic [31:0] OP3_B = {8'd1, 8'd0, 8'd0, 8'd1};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset outs", {start, busy, done, a0_out, a1_out, b0_out, b1_out}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("reset ready", {62'd0, in_ready, busy}, 64'd2);

    // Single op with hand-computed streams and product
    issue(OP1_A, OP1_B);
    watch_op("op1", OP1_A, OP1_B, {16'd19, 16'd22, 16'd43, 16'd50}, 0);
    check("op1 hand k0", {32'd0, cap[0]}, {32'd0, 8'd1, 8'd0, 8'd5, 8'd0});
    check("op1 hand k1", {32'd0, cap[1]}, {32'd0, 8'd2, 8'd3, 8'd7, 8'd6});
    check("op1 hand k2", {32'd0, cap[2]}, {32'd0, 8'd0, 8'd4, 8'd0, 8'd8});
    check("op1 hand k3", {32'd0, cap[3]}, 64'd0);

    // Back-to-back with in_valid held high across both ops
    @(negedge clk);
    in_valid = 1'b1; in_a = OP1_A; in_b = OP1_B;
    @(negedge clk);
    in_a = OP2_A; in_b = OP2_B;
    watch_op("b2b1", OP1_A, OP1_B, {16'd19, 16'd22, 16'd43, 16'd50}, 0);
    @(negedge clk);
    in_valid = 1'b0;
    watch_op("b2b2", OP2_A, OP2_B, {16'd8, 16'd2, 16'd4, 16'd7}, 0);

    // Reset while FEED is at k=5
    issue(OP1_A, OP1_B);
    repeat (7) @(negedge clk);
    check("pre-rst busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst outs", {start, busy, done, a0_out, a1_out, b0_out, b1_out}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst ready", {61'd0, in_ready, busy, done}, 64'd4);
    begin
      int dn = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done || busy) dn++;
      end
      check("midrst no done", 64'(dn), 64'd0);
    end
    issue(OP3_A, OP3_B);
    watch_op("post-rst", OP3_A, OP3_B, {16'd5, 16'd6, 16'd7, 16'd8}, 0);

    // Reset wins over a transfer on the same edge
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_a = OP2_A; in_b = OP2_B;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check("rst prio", {61'd0, busy, start, in_ready}, 64'd1);
    @(negedge clk);
    check("rst prio next", {62'd0, busy, start}, 64'd0);

    // Operand offer while busy must be ignored
    issue(OP1_A, OP1_B);
    watch_op("busy-offer", OP1_A, OP1_B, {16'd19, 16'd22, 16'd43, 16'd50}, 6);

    // All-ones extremes
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    watch_op("extreme", 32'hFFFF_FFFF, 32'hFFFF_FFFF, {16'hFC02, 16'hFC02, 16'hFC02, 16'hFC02}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
